// File: rtl/l1_refill_ctrl.sv
// l1_refill_ctrl: one-line-at-a-time burst refill engine feeding the L1 data RAM write port.
// Define L1_REFILL_BYPASS_EN to add the critical-word bypass outputs (byp_valid/byp_data).
module l1_refill_ctrl #(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned LINE_WORDS     = 4,
    parameter int unsigned MEM_ADDR_WIDTH = 32
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        req_valid,
    output logic                                        req_ready,
    input  logic [MEM_ADDR_WIDTH-1:0]                   req_addr,
    input  logic [ADDR_WIDTH-$clog2(LINE_WORDS)-1:0]    req_index,
    output logic                                        mem_arvalid,
    input  logic                                        mem_arready,
    output logic [MEM_ADDR_WIDTH-1:0]                   mem_araddr,
    output logic [7:0]                                  mem_arlen,
    input  logic                                        mem_rvalid,
    output logic                                        mem_rready,
    input  logic [DATA_WIDTH-1:0]                       mem_rdata,
    input  logic                                        mem_rlast,
    output logic                                        ram_wen,
    output logic [ADDR_WIDTH-1:0]                       ram_waddr,
    output logic [DATA_WIDTH-1:0]                       ram_wdata,
    output logic                                        done,
    output logic                                        err
`ifdef L1_REFILL_BYPASS_EN
    ,
    output logic                                        byp_valid,
    output logic [DATA_WIDTH-1:0]                       byp_data
`endif
);

    localparam int unsigned BEAT_W   = $clog2(LINE_WORDS);
    localparam int unsigned INDEX_W  = ADDR_WIDTH - BEAT_W;
    localparam int unsigned BYTE_W   = $clog2(DATA_WIDTH / 8);
    localparam int unsigned LINE_LSB = BEAT_W + BYTE_W;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

    state_t                       r_state;
    state_t                       w_next;
    logic [MEM_ADDR_WIDTH-1:0]    r_addr;
    logic [INDEX_W-1:0]           r_index;
    logic [BEAT_W-1:0]            r_beat;
    logic                         r_err;
    logic                         w_beat_fire;
    logic                         w_last;
    logic                         w_proto_err;
    logic                         w_unused;

    assign w_beat_fire = (r_state == S_DATA) && mem_rvalid;
    assign w_last      = (r_beat == LAST_BEAT);
    // Error when rlast disagrees with the beat count: early rlast or missing rlast.
    assign w_proto_err = w_beat_fire && (w_last != mem_rlast);

`ifdef L1_REFILL_BYPASS_EN
    logic [BEAT_W-1:0]            r_woff;
    assign w_unused = ^req_addr[BYTE_W-1:0];
`else
    assign w_unused = ^req_addr[LINE_LSB-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (req_valid)                       w_next = S_ADDR;
            S_ADDR:  if (mem_arready)                     w_next = S_DATA;
            S_DATA:  if (w_beat_fire && (w_last || mem_rlast)) w_next = S_DONE;
            S_DONE:                                       w_next = S_IDLE;
            default:                                      w_next = S_IDLE;
        endcase
    end

    // Address/data buses are gated to zero outside their valid phase.
    always_comb begin
        req_ready   = 1'b0;
        mem_arvalid = 1'b0;
        mem_araddr  = '0;
        mem_arlen   = 8'd0;
        mem_rready  = 1'b0;
        ram_wen     = 1'b0;
        ram_waddr   = '0;
        ram_wdata   = '0;
        done        = 1'b0;
        err         = 1'b0;
`ifdef L1_REFILL_BYPASS_EN
        byp_valid   = 1'b0;
        byp_data    = '0;
`endif
        case (r_state)
            S_IDLE: req_ready = 1'b1;
            S_ADDR: begin
                mem_arvalid = 1'b1;
                mem_araddr  = r_addr;
                mem_arlen   = 8'(LINE_WORDS - 1);
            end
            S_DATA: begin
                mem_rready = 1'b1;
                if (mem_rvalid) begin
                    ram_wen   = 1'b1;
                    ram_waddr = {r_index, r_beat};
                    ram_wdata = mem_rdata;
`ifdef L1_REFILL_BYPASS_EN
                    if (r_beat == r_woff) begin
                        byp_valid = 1'b1;
                        byp_data  = mem_rdata;
                    end
`endif
                end
            end
            S_DONE: begin
                done = 1'b1;
                err  = r_err;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_index <= '0;
            r_beat  <= '0;
            r_err   <= 1'b0;
`ifdef L1_REFILL_BYPASS_EN
            r_woff  <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (req_valid) begin
                    r_addr  <= {req_addr[MEM_ADDR_WIDTH-1:LINE_LSB], LINE_LSB'(0)};
                    r_index <= req_index;
                    r_beat  <= '0;
                    r_err   <= 1'b0;
`ifdef L1_REFILL_BYPASS_EN
                    r_woff  <= req_addr[LINE_LSB-1:BYTE_W];
`endif
                end
                S_DATA: begin
                    if (w_beat_fire && !w_last) r_beat <= r_beat + BEAT_W'(1);
                    if (w_proto_err)            r_err  <= 1'b1;
                end
                S_DONE: r_err <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_l1_refill_ctrl.sv
// Directed, table-driven bench for l1_refill_ctrl: fill scenarios plus a reset-abort sequence.
module tb_l1_refill_ctrl;

    localparam int unsigned AW  = 16;
    localparam int unsigned DW  = 32;
    localparam int unsigned LW  = 4;
    localparam int unsigned MAW = 32;
    localparam int unsigned IW  = 14;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           req_valid;
    logic           req_ready;
    logic [MAW-1:0] req_addr;
    logic [IW-1:0]  req_index;
    logic           mem_arvalid;
    logic           mem_arready;
    logic [MAW-1:0] mem_araddr;
    logic [7:0]     mem_arlen;
    logic           mem_rvalid;
    logic           mem_rready;
    logic [DW-1:0]  mem_rdata;
    logic           mem_rlast;
    logic           ram_wen;
    logic [AW-1:0]  ram_waddr;
    logic [DW-1:0]  ram_wdata;
    logic           done;
    logic           err;
`ifdef L1_REFILL_BYPASS_EN
    logic           byp_valid;
    logic [DW-1:0]  byp_data;
`endif

    always #5 clk = ~clk;

    l1_refill_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(LW), .MEM_ADDR_WIDTH(MAW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_index(req_index),
        .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
        .mem_arlen(mem_arlen), .mem_rvalid(mem_rvalid), .mem_rready(mem_rready),
        .mem_rdata(mem_rdata), .mem_rlast(mem_rlast),
        .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .done(done), .err(err)
`ifdef L1_REFILL_BYPASS_EN
        , .byp_valid(byp_valid), .byp_data(byp_data)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        logic [13:0] index;
        int          ar_wait;     // cycles arready stays low
        bit          gap;         // rvalid toggles 1,0,1,0
        int          rlast_beat;  // beat carrying rlast; 4 = never
        logic [31:0] dbase;       // beat k returns dbase+k
    } vec_t;

    vec_t vecs[5];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_fill(input vec_t v);
        logic [31:0] al;
        logic [15:0] wa;
        int          term;
        bit          exp_err;
        bit          rv;
        int          k;
        int          d;
`ifdef L1_REFILL_BYPASS_EN
        logic [1:0]  woff;
        woff = v.addr[3:2];
`endif
        al      = {v.addr[31:4], 4'h0};
        term    = (v.rlast_beat < int'(LW - 1)) ? v.rlast_beat : int'(LW - 1);
        exp_err = (v.rlast_beat != int'(LW - 1));
        k = 0;
        d = 0;
        // cycle 0: request accepted in IDLE
        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = v.addr; req_index = v.index;
        mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rlast = 1'b0;
        @(negedge clk);
        chk("req_ready_idle", req_ready, 1);
        chk("done_idle", done, 0);
        chk("arvalid_idle", mem_arvalid, 0);
        // address phase; junk request must be ignored
        for (int c = 1; c <= 1 + v.ar_wait; c++) begin
            @(posedge clk); #1;
            req_valid = 1'b1; req_addr = ~v.addr; req_index = ~v.index;
            mem_arready = (c == 1 + v.ar_wait);
            @(negedge clk);
            chk("req_ready_busy", req_ready, 0);
            chk("arvalid", mem_arvalid, 1);
            chk("araddr", mem_araddr, al);
            chk("arlen", mem_arlen, LW - 1);
            chk("rready_addr", mem_rready, 0);
            chk("wen_addr", ram_wen, 0);
        end
        // data phase
        while (k <= term) begin
            @(posedge clk); #1;
            mem_arready = 1'b0;
            rv = !v.gap || (d % 2 == 0);
            d++;
            mem_rvalid = rv;
            mem_rdata  = rv ? v.dbase + 32'(k) : 32'hDEAD_BEEF;
            mem_rlast  = rv && (k == v.rlast_beat);
            @(negedge clk);
            chk("arvalid_data", mem_arvalid, 0);
            chk("rready", mem_rready, 1);
            chk("wen", ram_wen, rv);
            chk("done_data", done, 0);
            if (rv) begin
                wa = {v.index, 2'(k)};
                chk("waddr", ram_waddr, wa);
                chk("wdata", ram_wdata, v.dbase + 32'(k));
            end
`ifdef L1_REFILL_BYPASS_EN
            chk("byp_valid", byp_valid, rv && (k == int'(woff)));
            if (rv && (k == int'(woff))) chk("byp_data", byp_data, v.dbase + 32'(k));
`endif
            if (rv) k++;
        end
        // done cycle
        @(posedge clk); #1;
        mem_rvalid = 1'b0; mem_rlast = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("done", done, 1);
        chk("err", err, exp_err);
        chk("wen_done", ram_wen, 0);
        chk("rready_done", mem_rready, 0);
        chk("req_ready_done", req_ready, 0);
    endtask

    initial begin
        vec_t rec;
        vecs[0] = '{32'h0000_1234, 14'd5,      0, 1'b0, 3, 32'h0000_00A0};
        vecs[1] = '{32'h0000_0ABC, 14'h3FFF,   3, 1'b1, 3, 32'h0000_00C0};
        vecs[2] = '{32'h0000_1238, 14'd7,      0, 1'b0, 1, 32'h0000_00D0};
        vecs[3] = '{32'hFFFF_FFF0, 14'd1,      1, 1'b0, 4, 32'h0000_00E0};
        vecs[4] = '{32'h0000_1238, 14'd2,      0, 1'b1, 3, 32'h0000_00F0};

        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_index = '0;
        mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_rlast = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_arvalid", mem_arvalid, 0);
        chk("rst_araddr", mem_araddr, 0);
        chk("rst_rready", mem_rready, 0);
        chk("rst_wen", ram_wen, 0);
        chk("rst_waddr", ram_waddr, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
`ifdef L1_REFILL_BYPASS_EN
        chk("rst_byp", byp_valid, 0);
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 5; i++) run_fill(vecs[i]);

        // reset dropped after two beats of a fill
        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = 32'h0000_5550; req_index = 14'd9;
        @(posedge clk); #1;
        req_valid = 1'b0; mem_arready = 1'b1;
        @(posedge clk); #1;
        mem_arready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hB0; mem_rlast = 1'b0;
        @(negedge clk);
        chk("abort_wen0", ram_wen, 1);
        @(posedge clk); #1;
        mem_rdata = 32'hB1;
        @(negedge clk);
        chk("abort_wen1", ram_wen, 1);
        chk("abort_waddr1", ram_waddr, 16'h0025);
        @(posedge clk); #1;
        mem_rdata = 32'hB2; rst_n = 1'b0;
        @(negedge clk);
        chk("abort_wen_now", ram_wen, 0);
        chk("abort_req_ready", req_ready, 1);
        chk("abort_rready", mem_rready, 0);
        chk("abort_done", done, 0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            mem_rdata = 32'hB3;
            @(negedge clk);
            chk("abort_wen_hold", ram_wen, 0);
            chk("abort_done_hold", done, 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_wen", ram_wen, 0);
        chk("post_rst_done", done, 0);
        chk("post_rst_ready", req_ready, 1);
        mem_rvalid = 1'b0;

        rec = '{32'h0000_4444, 14'h2AAA, 0, 1'b0, 3, 32'h0000_0011};
        run_fill(rec);

        @(posedge clk); #1;
        @(negedge clk);
        chk("final_done_clear", done, 0);
        chk("final_idle", req_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
